// File: rtl/mcdt_arbiter_if.sv
// Channel-FIFO and output-port signals of the mcdt output arbiter.
// master: arbiter side; slave: channel FIFOs, config and downstream side.
interface mcdt_arbiter_if #(
  parameter int unsigned DW = 32
);
  logic          ch0_req_i;
  logic          ch1_req_i;
  logic          ch2_req_i;
  logic [DW-1:0] ch0_data_i;
  logic [DW-1:0] ch1_data_i;
  logic [DW-1:0] ch2_data_i;
  logic          ch0_ack_o;
  logic          ch1_ack_o;
  logic          ch2_ack_o;
  logic          cfg_ch0_en_i;
  logic          cfg_ch1_en_i;
  logic          cfg_ch2_en_i;
  logic [1:0]    cfg_ch0_prio_i;
  logic [1:0]    cfg_ch1_prio_i;
  logic [1:0]    cfg_ch2_prio_i;
  logic [DW-1:0] a_data_o;
  logic          a_val_o;
  logic [1:0]    a_id_o;
  logic          a_ready_i;

  modport master (
    input  ch0_req_i, ch1_req_i, ch2_req_i,
    input  ch0_data_i, ch1_data_i, ch2_data_i,
    output ch0_ack_o, ch1_ack_o, ch2_ack_o,
    input  cfg_ch0_en_i, cfg_ch1_en_i, cfg_ch2_en_i,
    input  cfg_ch0_prio_i, cfg_ch1_prio_i, cfg_ch2_prio_i,
    output a_data_o, a_val_o, a_id_o,
    input  a_ready_i
  );

  modport slave (
    output ch0_req_i, ch1_req_i, ch2_req_i,
    output ch0_data_i, ch1_data_i, ch2_data_i,
    input  ch0_ack_o, ch1_ack_o, ch2_ack_o,
    output cfg_ch0_en_i, cfg_ch1_en_i, cfg_ch2_en_i,
    output cfg_ch0_prio_i, cfg_ch1_prio_i, cfg_ch2_prio_i,
    input  a_data_o, a_val_o, a_id_o,
    output a_ready_i
  );
endinterface

// File: rtl/mcdt_arbiter.sv
// mcdt output arbiter: strict-priority selection of three channel FIFOs with
// round-robin tie-breaking, feeding a registered valid/ready output slot.
module mcdt_arbiter #(
  parameter int unsigned DW = 32
) (
  input  logic           clk,
  input  logic           rstn,
  mcdt_arbiter_if.master bus_if
);

  localparam int unsigned NCH = 3;
  localparam int unsigned IDW = 2;
  localparam int unsigned PW  = 2;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_e;

  slot_e           slot_q, slot_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;

  logic [NCH-1:0]  req;
  logic [NCH-1:0]  en;
  logic [NCH-1:0]  elig;
  logic [NCH-1:0]  ack_c;
  logic [PW-1:0]   prio [NCH];
  logic [DW-1:0]   data [NCH];

  logic            open_c;
  logic [PW-1:0]   min_prio;
  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  scan;

  // Mod-3 successor of a channel id; the value 3 is never produced.
  function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
    return (id >= IDW'(NCH - 1)) ? '0 : id + IDW'(1);
  endfunction

  assign req     = {bus_if.ch2_req_i, bus_if.ch1_req_i, bus_if.ch0_req_i};
  assign en      = {bus_if.cfg_ch2_en_i, bus_if.cfg_ch1_en_i, bus_if.cfg_ch0_en_i};
  assign elig    = req & en;
  assign prio[0] = bus_if.cfg_ch0_prio_i;
  assign prio[1] = bus_if.cfg_ch1_prio_i;
  assign prio[2] = bus_if.cfg_ch2_prio_i;
  assign data[0] = bus_if.ch0_data_i;
  assign data[1] = bus_if.ch1_data_i;
  assign data[2] = bus_if.ch2_data_i;

  assign open_c = (slot_q == SLOT_EMPTY) || bus_if.a_ready_i;

  // Best (numerically lowest) priority among eligible channels.
  always_comb begin
    min_prio = '1;
    for (int i = 0; i < int'(NCH); i++) begin
      if (elig[i] && (prio[i] < min_prio)) begin
        min_prio = prio[i];
      end
    end
  end

  // Rotate from the channel after the last winner; first match at min_prio wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    scan    = last_q;
    for (int k = 0; k < int'(NCH); k++) begin
      scan = next_id(scan);
      if (!win_vld && elig[scan] && (prio[scan] == min_prio)) begin
        win_vld = 1'b1;
        win_id  = scan;
      end
    end
  end

  // Pop strobe for the winner, only when the slot can take it and not in reset.
  always_comb begin
    ack_c = '0;
    if (open_c && win_vld && !rstn) begin
      ack_c[win_id] = 1'b1;
    end
  end

  // Output slot next state: load winner, drain to empty, or hold under backpressure.
  always_comb begin
    slot_d = slot_q;
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (open_c) begin
      if (win_vld) begin
        slot_d = SLOT_FULL;
        data_d = data[win_id];
        id_d   = win_id;
        last_d = win_id;
      end else begin
        slot_d = SLOT_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      slot_q <= SLOT_EMPTY;
      data_q <= '0;
      id_q   <= '0;
      last_q <= IDW'(NCH - 1);
    end else begin
      slot_q <= slot_d;
      data_q <= data_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign bus_if.ch0_ack_o = ack_c[0];
  assign bus_if.ch1_ack_o = ack_c[1];
  assign bus_if.ch2_ack_o = ack_c[2];
  assign bus_if.a_val_o   = (slot_q == SLOT_FULL);
  assign bus_if.a_data_o  = data_q;
  assign bus_if.a_id_o    = id_q;

endmodule

// File: tb/tb_mcdt_arbiter.sv
// Testbench for mcdt_arbiter: directed scenarios plus a randomized run, all
// checked against a queue-based model of channel FIFOs and the output slot.
module tb_mcdt_arbiter;

  localparam int unsigned DW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  mcdt_arbiter_if #(.DW(DW)) bus_if ();

  mcdt_arbiter #(.DW(DW)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Channel FIFO contents (popped on modelled acks) and per-channel send order.
  logic [DW-1:0] fifo [3][$];
  logic [DW-1:0] sent [3][$];
  bit            en   [3];
  int            pr   [3];
  bit            rdy;

  // Model of the output slot and round-robin pointer.
  bit            m_val;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_last;

  logic [2:0] ack;
  assign ack = {bus_if.ch2_ack_o, bus_if.ch1_ack_o, bus_if.ch0_ack_o};

  task automatic drive();
    bus_if.ch0_req_i      = (fifo[0].size() != 0);
    bus_if.ch1_req_i      = (fifo[1].size() != 0);
    bus_if.ch2_req_i      = (fifo[2].size() != 0);
    bus_if.ch0_data_i     = (fifo[0].size() != 0) ? fifo[0][0] : '0;
    bus_if.ch1_data_i     = (fifo[1].size() != 0) ? fifo[1][0] : '0;
    bus_if.ch2_data_i     = (fifo[2].size() != 0) ? fifo[2][0] : '0;
    bus_if.cfg_ch0_en_i   = en[0];
    bus_if.cfg_ch1_en_i   = en[1];
    bus_if.cfg_ch2_en_i   = en[2];
    bus_if.cfg_ch0_prio_i = 2'(pr[0]);
    bus_if.cfg_ch1_prio_i = 2'(pr[1]);
    bus_if.cfg_ch2_prio_i = 2'(pr[2]);
    bus_if.a_ready_i      = rdy;
  endtask

  // Winner per the priority/rotation rule, or -1 if no arbitration happens.
  function automatic int pick();
    int best;
    int w;
    int c;
    best = 4;
    w    = -1;
    if (m_val && !rdy) return -1;
    for (int n = 0; n < 3; n++)
      if (fifo[n].size() != 0 && en[n] && pr[n] < best) best = pr[n];
    for (int k = 1; k <= 3; k++) begin
      c = (m_last + k) % 3;
      if (w < 0 && fifo[c].size() != 0 && en[c] && pr[c] == best) w = c;
    end
    return w;
  endfunction

  function automatic logic [2:0] exp_ack();
    int w;
    w = pick();
    if (rstn || w < 0) return 3'b000;
    return 3'(1 << w);
  endfunction

  function automatic void model_reset();
    m_val  = 1'b0;
    m_data = '0;
    m_id   = 0;
    m_last = 2;
  endfunction

  // Advance one clock edge, updating the model, then re-drive inputs.
  task automatic commit();
    int w;
    w = pick();
    @(posedge clk);
    if (!rstn) begin
      if (w >= 0) begin
        m_val  = 1'b1;
        m_data = fifo[w].pop_front();
        m_id   = w;
        m_last = w;
      end else if (!m_val || rdy) begin
        m_val = 1'b0;
      end
    end
    #1;
    drive();
  endtask

  task automatic push(input int ch, input logic [DW-1:0] d);
    fifo[ch].push_back(d);
    sent[ch].push_back(d);
  endtask

  task automatic reset_dut();
    rstn = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      fifo[ch].delete();
      sent[ch].delete();
      en[ch] = 1'b1;
      pr[ch] = 0;
    end
    rdy = 1'b1;
    model_reset();
    drive();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      en[ch] = 1'b1;
      pr[ch] = 0;
      push(ch, 32'hE000_0000 + DW'(ch));
    end
    rdy = 1'b1;
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus_if.a_val_o !== 1'b0) begin bad++; $display("FAIL reset_val got=%0b want=0", bus_if.a_val_o); end
    total++; if (bus_if.a_data_o !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", bus_if.a_data_o); end
    total++; if (bus_if.a_id_o !== 2'd0) begin bad++; $display("FAIL reset_id got=%0d want=0", bus_if.a_id_o); end
    total++; if (ack !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b want=000", ack); end
    reset_dut();
  endtask

  task automatic test_rotation();
    reset_dut();
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < 4; i++) push(ch, 32'hA000_0000 + DW'(ch << 8) + DW'(i));
    drive();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (bus_if.a_val_o !== 1'b0) begin bad++; $display("FAIL rot_first_val got=%0b want=0", bus_if.a_val_o); end
        total++; if (ack !== 3'b001) begin bad++; $display("FAIL rot_first_ack got=%b want=001", ack); end
      end else begin
        total++; if (bus_if.a_val_o !== 1'b1) begin bad++; $display("FAIL rot_val c=%0d got=%0b want=1", c, bus_if.a_val_o); end
        total++; if (bus_if.a_id_o !== 2'((c - 1) % 3)) begin bad++; $display("FAIL rot_id c=%0d got=%0d want=%0d", c, bus_if.a_id_o, (c - 1) % 3); end
        total++;
        if (bus_if.a_data_o !== 32'hA000_0000 + DW'(((c - 1) % 3) << 8) + DW'((c - 1) / 3)) begin
          bad++; $display("FAIL rot_data c=%0d got=%h", c, bus_if.a_data_o);
        end
      end
      commit();
    end
  endtask

  task automatic test_priority();
    int            eid  [12];
    logic [DW-1:0] edat [12];
    int            k;
    reset_dut();
    pr[0] = 1; pr[1] = 0; pr[2] = 1;
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h00C0_0000 + DW'(i));
      push(1, 32'h00C1_0000 + DW'(i));
      push(2, 32'h00C2_0000 + DW'(i));
      eid[i] = 1;          edat[i]         = 32'h00C1_0000 + DW'(i);
      eid[4 + 2 * i] = 2;  edat[4 + 2 * i] = 32'h00C2_0000 + DW'(i);
      eid[5 + 2 * i] = 0;  edat[5 + 2 * i] = 32'h00C0_0000 + DW'(i);
    end
    drive();
    k = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus_if.a_val_o === 1'b1) begin
        total++;
        if (k >= 12) begin
          bad++; $display("FAIL prio_extra got=%h want=none", bus_if.a_data_o);
        end else if (bus_if.a_id_o !== 2'(eid[k]) || bus_if.a_data_o !== edat[k]) begin
          bad++; $display("FAIL prio_word k=%0d got=%0d/%h want=%0d/%h", k, bus_if.a_id_o, bus_if.a_data_o, eid[k], edat[k]);
        end
        k++;
      end
      commit();
    end
    total++; if (k != 12) begin bad++; $display("FAIL prio_count got=%0d want=12", k); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < 3; i++) push(ch, 32'hB000_0000 + DW'(ch << 8) + DW'(i));
    drive();
    @(negedge clk);
    total++; if (ack !== 3'b001) begin bad++; $display("FAIL bp_first_ack got=%b want=001", ack); end
    commit();
    rdy = 1'b0;
    drive();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (bus_if.a_val_o !== 1'b1) begin bad++; $display("FAIL bp_val c=%0d got=%0b want=1", c, bus_if.a_val_o); end
      total++; if (bus_if.a_id_o !== 2'd0) begin bad++; $display("FAIL bp_id c=%0d got=%0d want=0", c, bus_if.a_id_o); end
      total++; if (bus_if.a_data_o !== 32'hB000_0000) begin bad++; $display("FAIL bp_data c=%0d got=%h want=b0000000", c, bus_if.a_data_o); end
      total++; if (ack !== 3'b000) begin bad++; $display("FAIL bp_ack c=%0d got=%b want=000", c, ack); end
      commit();
    end
    rdy = 1'b1;
    drive();
    @(negedge clk);
    total++; if (ack !== 3'b010) begin bad++; $display("FAIL bp_release_ack got=%b want=010", ack); end
    commit();
    @(negedge clk);
    total++;
    if (bus_if.a_val_o !== 1'b1 || bus_if.a_id_o !== 2'd1 || bus_if.a_data_o !== 32'hB000_0100) begin
      bad++; $display("FAIL bp_next got=%0b/%0d/%h want=1/1/b0000100", bus_if.a_val_o, bus_if.a_id_o, bus_if.a_data_o);
    end
    commit();
  endtask

  task automatic test_disable();
    reset_dut();
    en[2] = 1'b0;
    push(2, 32'hC200_0000);
    push(2, 32'hC200_0001);
    drive();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (ack !== 3'b000) begin bad++; $display("FAIL dis_ack c=%0d got=%b want=000", c, ack); end
      total++; if (bus_if.a_val_o !== 1'b0) begin bad++; $display("FAIL dis_val c=%0d got=%0b want=0", c, bus_if.a_val_o); end
      commit();
    end
    en[2] = 1'b1;
    drive();
    @(negedge clk);
    total++; if (ack !== 3'b100) begin bad++; $display("FAIL dis_reen_ack got=%b want=100", ack); end
    commit();
    rdy   = 1'b0;
    en[2] = 1'b0;
    drive();
    @(negedge clk);
    total++;
    if (bus_if.a_val_o !== 1'b1 || bus_if.a_id_o !== 2'd2 || bus_if.a_data_o !== 32'hC200_0000 || ack !== 3'b000) begin
      bad++; $display("FAIL dis_hold got=%0b/%0d/%h/%b want=1/2/c2000000/000", bus_if.a_val_o, bus_if.a_id_o, bus_if.a_data_o, ack);
    end
    commit();
    rdy = 1'b1;
    drive();
    @(negedge clk);
    total++; if (bus_if.a_val_o !== 1'b1 || bus_if.a_id_o !== 2'd2) begin bad++; $display("FAIL dis_deliver got=%0b/%0d want=1/2", bus_if.a_val_o, bus_if.a_id_o); end
    commit();
    @(negedge clk);
    total++; if (bus_if.a_val_o !== 1'b0) begin bad++; $display("FAIL dis_drain got=%0b want=0", bus_if.a_val_o); end
    commit();
  endtask

  task automatic test_async_reset();
    reset_dut();
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < 2; i++) push(ch, 32'hD000_0000 + DW'(ch << 8) + DW'(i));
    rdy = 1'b0;
    drive();
    commit();
    #2;
    rstn = 1'b1;
    #1;
    total++; if (bus_if.a_val_o !== 1'b0) begin bad++; $display("FAIL areset_val got=%0b want=0", bus_if.a_val_o); end
    model_reset();
    rdy = 1'b1;
    drive();
    @(negedge clk);
    total++; if (ack !== 3'b000) begin bad++; $display("FAIL areset_ack got=%b want=000", ack); end
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    commit();
    @(negedge clk);
    total++;
    if (bus_if.a_val_o !== 1'b1 || bus_if.a_id_o !== 2'd0 || bus_if.a_data_o !== 32'hD000_0001) begin
      bad++; $display("FAIL areset_first got=%0b/%0d/%h want=1/0/d0000001", bus_if.a_val_o, bus_if.a_id_o, bus_if.a_data_o);
    end
    commit();
  endtask

  task automatic test_random();
    int seq [3];
    int id;
    reset_dut();
    for (int ch = 0; ch < 3; ch++) seq[ch] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (fifo[ch].size() < 4 && $urandom_range(0, 1) == 1) begin
          push(ch, (DW'(ch) << 24) | DW'(seq[ch]));
          seq[ch]++;
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        for (int ch = 0; ch < 3; ch++) begin
          en[ch] = ($urandom_range(0, 3) != 0);
          pr[ch] = int'($urandom_range(0, 3));
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      drive();
      @(negedge clk);
      total++; if (ack !== exp_ack()) begin bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, ack, exp_ack()); end
      total++; if ($countones(ack) > 1) begin bad++; $display("FAIL rnd_onehot c=%0d got=%b want=<=1 bit", c, ack); end
      total++; if (bus_if.a_id_o === 2'd3) begin bad++; $display("FAIL rnd_id3 c=%0d got=3 want=0..2", c); end
      total++; if (bus_if.a_val_o !== m_val) begin bad++; $display("FAIL rnd_val c=%0d got=%0b want=%0b", c, bus_if.a_val_o, m_val); end
      if (m_val) begin
        total++;
        if (bus_if.a_data_o !== m_data || bus_if.a_id_o !== 2'(m_id)) begin
          bad++; $display("FAIL rnd_out c=%0d got=%0d/%h want=%0d/%h", c, bus_if.a_id_o, bus_if.a_data_o, m_id, m_data);
        end
      end
      if (bus_if.a_val_o === 1'b1 && rdy) begin
        id = int'(bus_if.a_id_o);
        total++;
        if (id > 2 || sent[id].size() == 0) begin
          bad++; $display("FAIL rnd_sb_empty c=%0d got=%0d/%h want=pending word", c, id, bus_if.a_data_o);
        end else begin
          if (bus_if.a_data_o !== sent[id][0]) begin
            bad++; $display("FAIL rnd_sb_order c=%0d got=%h want=%h", c, bus_if.a_data_o, sent[id][0]);
          end
          void'(sent[id].pop_front());
        end
      end
      commit();
    end
  endtask

  initial begin
    for (int ch = 0; ch < 3; ch++) begin
      en[ch] = 1'b0;
      pr[ch] = 0;
    end
    rdy = 1'b0;
    model_reset();
    drive();
    test_reset();
    test_rotation();
    test_priority();
    test_backpressure();
    test_disable();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
